// File: rtl/minirisc_ctrl_pkg.sv
// Shared encodings for the KGP-miniRISC control sequencer: states, opcode classes,
// branch conditions and datapath select codes.
package minirisc_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } ctrl_state_e;

  localparam logic [2:0] ClsAluReg = 3'b000;
  localparam logic [2:0] ClsAluImm = 3'b001;
  localparam logic [2:0] ClsLoad   = 3'b010;
  localparam logic [2:0] ClsStore  = 3'b011;
  localparam logic [2:0] ClsBranch = 3'b100;
  localparam logic [2:0] ClsJal    = 3'b101;
  localparam logic [2:0] ClsJr     = 3'b110;
  localparam logic [2:0] ClsSys    = 3'b111;

  localparam logic [2:0] CondAlways  = 3'b000;
  localparam logic [2:0] CondZero    = 3'b001;
  localparam logic [2:0] CondNotZero = 3'b010;
  localparam logic [2:0] CondSign    = 3'b011;
  localparam logic [2:0] CondNotSign = 3'b100;
  localparam logic [2:0] CondCarry   = 3'b101;

  localparam logic [1:0] AluInReg  = 2'b00;
  localparam logic [1:0] AluInImm  = 2'b01;
  localparam logic [1:0] AluInAddr = 2'b10;

  localparam logic [1:0] PcInc    = 2'b00;
  localparam logic [1:0] PcTarget = 2'b01;
  localparam logic [1:0] PcReg    = 2'b10;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  function automatic logic [2:0] op_class(logic [5:0] op);
    return op[5:3];
  endfunction

endpackage

// File: rtl/minirisc_control_fsm_if.sv
// Control/status bundle between the sequencer (master) and the datapath (slave).
interface minirisc_control_fsm_if;
  logic [5:0] opcode;
  logic [2:0] flags;
  logic       mem_ready;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       DataPCSel;
  logic       RegSelect;
  logic [2:0] ALUop;
  logic [1:0] ALUinSel;
  logic       pc_write;
  logic [1:0] pc_sel;
  logic       retire;
  logic       halted;
  logic       mem_error;
  logic       illegal;

  modport master (
    input  opcode, flags, mem_ready,
    output RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect, ALUop, ALUinSel,
           pc_write, pc_sel, retire, halted, mem_error, illegal
  );

  modport slave (
    output opcode, flags, mem_ready,
    input  RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect, ALUop, ALUinSel,
           pc_write, pc_sel, retire, halted, mem_error, illegal
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator; flags are {carry, sign, zero}.
module branch_cond_eval
  import minirisc_ctrl_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] flags_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      CondAlways:  taken_o = 1'b1;
      CondZero:    taken_o = flags_i[0];
      CondNotZero: taken_o = ~flags_i[0];
      CondSign:    taken_o = flags_i[1];
      CondNotSign: taken_o = ~flags_i[1];
      CondCarry:   taken_o = flags_i[2];
      default:     taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/minirisc_control_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with a bounded
// data-memory wait and a sticky timeout error.
module minirisc_control_fsm
  import minirisc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input logic                    clk,
  input logic                    reset,
  minirisc_control_fsm_if.master bus
);

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e      state_q, state_d;
  logic [5:0]       ir_op_q, ir_op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_error_q, mem_error_d;

  logic [2:0] cls;
  logic       taken;
  logic       reg_write, mem_read, mem_write, mem_to_reg, data_pc_sel, reg_select;
  logic [2:0] alu_op;
  logic [1:0] alu_in_sel, pc_sel;
  logic       pc_write, retire, illegal;

  assign cls = op_class(ir_op_q);

  branch_cond_eval u_branch_cond_eval (
    .cond_i  (ir_op_q[2:0]),
    .flags_i (bus.flags),
    .taken_o (taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StFetch;
      ir_op_q     <= '0;
      cnt_q       <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_op_q     <= ir_op_d;
      cnt_q       <= cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_op_d     = ir_op_q;
    cnt_d       = '0;
    mem_error_d = mem_error_q;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    data_pc_sel = 1'b0;
    reg_select  = 1'b0;
    alu_op      = 3'b000;
    alu_in_sel  = AluInReg;
    pc_write    = 1'b0;
    pc_sel      = PcInc;
    retire      = 1'b0;
    illegal     = 1'b0;

    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        ir_op_d = bus.opcode;
        if (bus.opcode == HALT_OPCODE) begin
          retire  = 1'b1;
          state_d = StHalt;
        end else begin
          illegal = (op_class(bus.opcode) == ClsSys);
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        unique case (cls)
          ClsAluReg, ClsAluImm: begin
            alu_op     = ir_op_q[2:0];
            alu_in_sel = (cls == ClsAluReg) ? AluInReg : AluInImm;
            state_d    = StWb;
          end
          ClsLoad, ClsStore: begin
            alu_in_sel = AluInAddr;
            state_d    = StMem;
          end
          ClsBranch: begin
            pc_write = 1'b1;
            retire   = 1'b1;
            pc_sel   = taken ? PcTarget : PcInc;
          end
          ClsJal: state_d = StWb;
          ClsJr: begin
            pc_write = 1'b1;
            retire   = 1'b1;
            pc_sel   = PcReg;
          end
          default: begin
            // Reserved opcodes behave as NOP
            pc_write = 1'b1;
            retire   = 1'b1;
          end
        endcase
      end
      StMem: begin
        mem_read  = (cls == ClsLoad);
        mem_write = (cls == ClsStore);
        if (bus.mem_ready) begin
          if (cls == ClsLoad) begin
            state_d = StWb;
          end else begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = StFetch;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == TimeoutLast) begin
            mem_error_d = 1'b1;
            state_d     = StHalt;
          end
        end
      end
      StWb: begin
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = StFetch;
        unique case (cls)
          ClsAluReg, ClsAluImm: begin
            reg_write  = 1'b1;
            alu_op     = ir_op_q[2:0];
            alu_in_sel = (cls == ClsAluReg) ? AluInReg : AluInImm;
          end
          ClsLoad: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
          end
          ClsJal: begin
            reg_write   = 1'b1;
            data_pc_sel = 1'b1;
            reg_select  = 1'b1;
            pc_sel      = PcTarget;
          end
          default: ;
        endcase
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  assign bus.RegWrite  = reg_write;
  assign bus.MemRead   = mem_read;
  assign bus.MemWrite  = mem_write;
  assign bus.MemtoReg  = mem_to_reg;
  assign bus.DataPCSel = data_pc_sel;
  assign bus.RegSelect = reg_select;
  assign bus.ALUop     = alu_op;
  assign bus.ALUinSel  = alu_in_sel;
  assign bus.pc_write  = pc_write;
  assign bus.pc_sel    = pc_sel;
  assign bus.retire    = retire;
  assign bus.illegal   = illegal;
  assign bus.halted    = (state_q == StHalt);
  assign bus.mem_error = mem_error_q;

endmodule

// File: tb/tb_minirisc_control_fsm.sv
// Directed and random instruction streams checked cycle by cycle against a per-instruction
// timeline model built from the opcode class rules.
module tb_minirisc_control_fsm;

  localparam int TO = 15;

  typedef struct packed {
    logic       rw, mr, mw, m2r, dps, rsel;
    logic [2:0] aluop;
    logic [1:0] alusel;
    logic       pcw;
    logic [1:0] pcsel;
    logic       ret, hlt, merr, ill;
  } out_t;

  typedef struct {
    bit         dec, exe, mem;
    logic [5:0] op;
    logic [2:0] flg;
    logic       rdy;
    out_t       e;
  } step_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  int     n_checks = 0;
  int     n_fail = 0;
  step_t  q[$];

  minirisc_control_fsm_if bus ();

  minirisc_control_fsm #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic out_t observe();
    out_t o;
    o.rw = bus.RegWrite;   o.mr = bus.MemRead;     o.mw = bus.MemWrite;
    o.m2r = bus.MemtoReg;  o.dps = bus.DataPCSel;  o.rsel = bus.RegSelect;
    o.aluop = bus.ALUop;   o.alusel = bus.ALUinSel;
    o.pcw = bus.pc_write;  o.pcsel = bus.pc_sel;   o.ret = bus.retire;
    o.hlt = bus.halted;    o.merr = bus.mem_error; o.ill = bus.illegal;
    return o;
  endfunction

  task automatic check(input string tag, input out_t exp);
    out_t obs;
    obs = observe();
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit br_taken(logic [2:0] c, logic [2:0] f);
    case (c)
      3'd0: return 1'b1;
      3'd1: return f[0];
      3'd2: return !f[0];
      3'd3: return f[1];
      3'd4: return !f[1];
      3'd5: return f[2];
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(bit dec, bit exe, bit mem, logic [5:0] op, logic [2:0] flg, logic rdy,
                      out_t e);
    step_t s;
    s.dec = dec; s.exe = exe; s.mem = mem; s.op = op; s.flg = flg; s.rdy = rdy; s.e = e;
    q.push_back(s);
  endtask

  // Expected per-cycle outputs of one instruction; wait_n >= TO means the memory never answers.
  task automatic model_instr(input logic [5:0] op, input logic [2:0] flg, input int wait_n,
                             output bit ends_halted);
    logic [2:0] cls;
    out_t z, e;
    int   n;
    cls = op[5:3];
    z = '0;
    ends_halted = 1'b0;
    push(0, 0, 0, op, flg, 1'b0, z);
    e = z; e.ill = (cls == 3'd7) && (op != 6'h3f); e.ret = (op == 6'h3f);
    push(1, 0, 0, op, flg, 1'b0, e);
    if (op == 6'h3f) begin
      e = z; e.hlt = 1'b1;
      repeat (3) push(0, 0, 0, op, flg, 1'b0, e);
      ends_halted = 1'b1;
      return;
    end
    case (cls)
      3'd0, 3'd1: begin
        e = z; e.aluop = op[2:0]; e.alusel = (cls == 3'd0) ? 2'b00 : 2'b01;
        push(0, 1, 0, op, flg, 1'b0, e);
        e.rw = 1'b1; e.pcw = 1'b1; e.ret = 1'b1;
        push(0, 0, 0, op, flg, 1'b0, e);
      end
      3'd2, 3'd3: begin
        e = z; e.alusel = 2'b10;
        push(0, 1, 0, op, flg, 1'b0, e);
        n = (wait_n >= TO) ? TO : wait_n;
        e = z; e.mr = (cls == 3'd2); e.mw = (cls == 3'd3);
        for (int i = 0; i < n; i++) push(0, 0, 1, op, flg, 1'b0, e);
        if (wait_n >= TO) begin
          e = z; e.hlt = 1'b1; e.merr = 1'b1;
          repeat (3) push(0, 0, 0, op, flg, 1'b0, e);
          ends_halted = 1'b1;
        end else if (cls == 3'd3) begin
          e.pcw = 1'b1; e.ret = 1'b1;
          push(0, 0, 1, op, flg, 1'b1, e);
        end else begin
          push(0, 0, 1, op, flg, 1'b1, e);
          e = z; e.rw = 1'b1; e.m2r = 1'b1; e.pcw = 1'b1; e.ret = 1'b1;
          push(0, 0, 0, op, flg, 1'b0, e);
        end
      end
      3'd4: begin
        e = z; e.pcw = 1'b1; e.ret = 1'b1; e.pcsel = br_taken(op[2:0], flg) ? 2'b01 : 2'b00;
        push(0, 1, 0, op, flg, 1'b0, e);
      end
      3'd5: begin
        push(0, 1, 0, op, flg, 1'b0, z);
        e = z; e.rw = 1'b1; e.dps = 1'b1; e.rsel = 1'b1; e.pcsel = 2'b01;
        e.pcw = 1'b1; e.ret = 1'b1;
        push(0, 0, 0, op, flg, 1'b0, e);
      end
      3'd6: begin
        e = z; e.pcw = 1'b1; e.ret = 1'b1; e.pcsel = 2'b10;
        push(0, 1, 0, op, flg, 1'b0, e);
      end
      default: begin
        e = z; e.pcw = 1'b1; e.ret = 1'b1;
        push(0, 1, 0, op, flg, 1'b0, e);
      end
    endcase
  endtask

  // Inputs that the sequencer must ignore in a given cycle are randomised.
  task automatic run_steps(input string tag, input int max_steps);
    step_t s;
    int    k;
    k = 0;
    while (q.size() > 0 && k < max_steps) begin
      s = q.pop_front();
      @(negedge clk);
      bus.opcode    = s.dec ? s.op  : 6'($urandom);
      bus.flags     = s.exe ? s.flg : 3'($urandom);
      bus.mem_ready = s.mem ? s.rdy : 1'($urandom);
      #1;
      check($sformatf("%s op=%b cyc%0d", tag, s.op, k), s.e);
      k++;
    end
  endtask

  task automatic reset_dut(input string tag);
    reset = 1'b1;
    #1;
    check(tag, '0);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input logic [2:0] flg,
                          input int wait_n);
    bit h;
    model_instr(op, flg, wait_n, h);
    run_steps(tag, 1000);
    if (h) reset_dut({tag, " reset"});
  endtask

  initial begin
    bit   h;
    logic [5:0] op;
    int   w;
    bus.opcode = '0; bus.flags = '0; bus.mem_ready = 1'b0;
    #2;
    reset_dut("por");

    model_instr(6'b000010, 3'b000, 0, h);
    run_steps("alu_pre", 3);
    q.delete();
    #1;
    reset_dut("reset_mid_exec");
    do_instr("alu", 6'b000010, 3'b000, 0);
    do_instr("load_w3", 6'b010000, 3'b000, 3);
    do_instr("store_timeout", 6'b011000, 3'b000, TO);
    do_instr("br_taken", 6'b100001, 3'b001, 0);
    do_instr("br_not", 6'b100001, 3'b000, 0);
    do_instr("jal", 6'b101000, 3'b000, 0);
    do_instr("jr", 6'b110000, 3'b000, 0);
    do_instr("illegal", 6'b111010, 3'b000, 0);
    do_instr("halt", 6'b111111, 3'b000, 0);
    do_instr("store_w0", 6'b011101, 3'b000, 0);
    do_instr("load_w0", 6'b010111, 3'b000, 0);
    do_instr("aluimm", 6'b001101, 3'b000, 0);

    for (int i = 0; i < 60; i++) begin
      op = 6'($urandom);
      w  = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 4));
      do_instr("rand", op, 3'($urandom), w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
